// File: rtl/morse_pkg.sv
// Shared Morse timing constants, FSM state encoding and the element-to-units helper.
// Pure declarations: no latency, no backpressure.
package morse_pkg;

    localparam int UNIT_W = 3;
    localparam int LEN_W  = 3;

    localparam logic [UNIT_W-1:0] DOT_UNITS        = 3'd1;
    localparam logic [UNIT_W-1:0] DASH_UNITS       = 3'd3;
    localparam logic [UNIT_W-1:0] ELEM_GAP_UNITS   = 3'd1;
    localparam logic [UNIT_W-1:0] LETTER_GAP_UNITS = 3'd3;
    localparam logic [UNIT_W-1:0] WORD_GAP_UNITS   = 3'd7;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MARK  = 2'd1;
    localparam logic [1:0] ST_SPACE = 2'd2;
    localparam logic [1:0] ST_LGAP  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        MARK  = ST_MARK,
        SPACE = ST_SPACE,
        LGAP  = ST_LGAP
    } state_t;

    function automatic logic [UNIT_W-1:0] elem_units(input logic is_dash);
        return is_dash ? DASH_UNITS : DOT_UNITS;
    endfunction

endpackage

// File: rtl/morse_sequencer_if.sv
// Character request / keyed-output bundle between encoder, sequencer and output stage.
// START is only honoured while BUSY is low; there is no other backpressure.
interface morse_sequencer_if #(
    parameter int MAX_LEN = 5
);
    import morse_pkg::*;

    logic                START;
    logic [LEN_W-1:0]    SYM_LEN;
    logic [MAX_LEN-1:0]  SYM_PAT;
    logic                BUSY;
    logic                MORSE_OUT;
    logic                DONE;

    modport master (
        output START, SYM_LEN, SYM_PAT,
        input  BUSY, MORSE_OUT, DONE
    );

    modport slave (
        input  START, SYM_LEN, SYM_PAT,
        output BUSY, MORSE_OUT, DONE
    );

endinterface

// File: rtl/unit_tick_gen.sv
// Restartable Morse unit prescaler: TICK is high in the last cycle of each UNIT_CYCLES window.
// CLR restarts the window at the next edge and masks TICK in that cycle; no backpressure.
module unit_tick_gen #(
    parameter int UNIT_CYCLES = 25000000,
    parameter int CNT_W       = 25
) (
    input  logic CLK,
    input  logic RST,
    input  logic CLR,
    output logic TICK
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(UNIT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             at_last;

    assign at_last = (cnt_q == LAST);
    assign TICK    = at_last && !CLR;

    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            cnt_q <= '0;
        end else if (at_last) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/morse_sequencer.sv
// Morse keying FSM: latches one character per accepted START and plays marks/gaps in unit ticks.
// MORSE_OUT/BUSY move on the accept edge; START is ignored while BUSY, DONE pulses one cycle at the end.
module morse_sequencer
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 25000000,
    parameter int CNT_W       = 25,
    parameter int MAX_LEN     = 5
) (
    input  logic              CLK,
    input  logic              RST,
    morse_sequencer_if.slave  bus
);

    state_t              state_q, state_n;
    logic [UNIT_W-1:0]   units_q, units_n;
    logic [LEN_W-1:0]    idx_q, idx_n;
    logic [LEN_W-1:0]    len_q, len_n;
    logic [MAX_LEN-1:0]  pat_q, pat_n;
    logic                busy_q, busy_n;
    logic                out_q, out_n;
    logic                done_q, done_n;
    logic                tick;
    logic                clr;
    logic                len_ok;
    logic                last_unit;

    unit_tick_gen #(
        .UNIT_CYCLES (UNIT_CYCLES),
        .CNT_W       (CNT_W)
    ) u_tick (
        .CLK  (CLK),
        .RST  (RST),
        .CLR  (clr),
        .TICK (tick)
    );

    assign len_ok    = (bus.SYM_LEN != '0) && (bus.SYM_LEN <= LEN_W'(MAX_LEN));
    assign last_unit = tick && (units_q == UNIT_W'(1));

    always_comb begin
        state_n = state_q;
        units_n = units_q;
        idx_n   = idx_q;
        len_n   = len_q;
        pat_n   = pat_q;
        busy_n  = busy_q;
        out_n   = out_q;
        done_n  = 1'b0;
        clr     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.START && len_ok) begin
                    clr     = 1'b1;
                    state_n = MARK;
                    pat_n   = bus.SYM_PAT;
                    len_n   = bus.SYM_LEN;
                    idx_n   = '0;
                    units_n = elem_units(bus.SYM_PAT[0]);
                    busy_n  = 1'b1;
                    out_n   = 1'b1;
                end else if (bus.START && (bus.SYM_LEN == '0)) begin
                    clr     = 1'b1;
                    state_n = LGAP;
                    units_n = WORD_GAP_UNITS;
                    busy_n  = 1'b1;
                end
            end
            MARK: begin
                if (last_unit) begin
                    out_n = 1'b0;
                    if ((idx_q + LEN_W'(1)) < len_q) begin
                        state_n = SPACE;
                        units_n = ELEM_GAP_UNITS;
                    end else begin
                        state_n = LGAP;
                        units_n = LETTER_GAP_UNITS;
                    end
                end else if (tick) begin
                    units_n = units_q - UNIT_W'(1);
                end
            end
            SPACE: begin
                if (last_unit) begin
                    // Pattern shifts down so the current element always sits in bit 0.
                    pat_n   = pat_q >> 1;
                    idx_n   = idx_q + LEN_W'(1);
                    units_n = elem_units(pat_n[0]);
                    state_n = MARK;
                    out_n   = 1'b1;
                end else if (tick) begin
                    units_n = units_q - UNIT_W'(1);
                end
            end
            LGAP: begin
                if (last_unit) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else if (tick) begin
                    units_n = units_q - UNIT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
                out_n   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            units_q <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            pat_q   <= '0;
            busy_q  <= 1'b0;
            out_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            units_q <= units_n;
            idx_q   <= idx_n;
            len_q   <= len_n;
            pat_q   <= pat_n;
            busy_q  <= busy_n;
            out_q   <= out_n;
            done_q  <= done_n;
        end
    end

    assign bus.BUSY      = busy_q;
    assign bus.MORSE_OUT = out_q;
    assign bus.DONE      = done_q;

endmodule

// File: tb/tb_morse_sequencer.sv
// Directed bench for morse_sequencer at UNIT_CYCLES=4: per-cycle output traces versus hand-built masks.
module tb_morse_sequencer;

    logic CLK = 1'b0;
    logic RST;

    morse_sequencer_if #(.MAX_LEN(5)) bus ();

    morse_sequencer #(
        .UNIT_CYCLES (4),
        .CNT_W       (3),
        .MAX_LEN     (5)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    logic [63:0] cap_out;
    logic [63:0] cap_busy;
    logic [63:0] cap_done;

    function automatic logic [63:0] ones(input int lo, input int hi);
        logic [63:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Pulse START for one edge; returns at the first negedge after the accept edge.
    task automatic start_sym(input logic [2:0] len, input logic [4:0] pat);
        bus.START   = 1'b1;
        bus.SYM_LEN = len;
        bus.SYM_PAT = pat;
        @(negedge CLK);
        bus.START   = 1'b0;
    endtask

    // Record n cycles of outputs; kind 1 = stray START(len 4), 2 = RST pulse, 3 = drop START.
    task automatic capture(input int n, input int act_at, input int kind);
        cap_out  = '0;
        cap_busy = '0;
        cap_done = '0;
        for (int i = 0; i < n; i++) begin
            cap_out[i]  = bus.MORSE_OUT;
            cap_busy[i] = bus.BUSY;
            cap_done[i] = bus.DONE;
            if (i == act_at) begin
                case (kind)
                    1: begin bus.START = 1'b1; bus.SYM_LEN = 3'd4; bus.SYM_PAT = 5'b01111; end
                    2: RST = 1'b1;
                    3: bus.START = 1'b0;
                    default: ;
                endcase
            end else if (i == act_at + 1) begin
                if (kind == 1) bus.START = 1'b0;
                if (kind == 2) RST = 1'b0;
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        logic any;
        RST = 1'b1;
        bus.START = 1'b0;
        bus.SYM_LEN = 3'd0;
        bus.SYM_PAT = 5'd0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if (bus.BUSY !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy: got %b expected 0", bus.BUSY);
        end
        checks++;
        if (bus.MORSE_OUT !== 1'b0) begin
            failures++;
            $display("FAIL reset_out: got %b expected 0", bus.MORSE_OUT);
        end
        checks++;
        if (bus.DONE !== 1'b0) begin
            failures++;
            $display("FAIL reset_done: got %b expected 0", bus.DONE);
        end
        any = 1'b0;
        repeat (50) begin
            any = any | bus.BUSY | bus.MORSE_OUT | bus.DONE;
            @(negedge CLK);
        end
        checks++;
        if (any !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle_activity: got %b expected 0", any);
        end
    endtask

    task automatic test_letter_a();
        logic [63:0] e_out, e_busy, e_done;
        start_sym(3'd2, 5'b00010);
        capture(40, -1, 0);
        e_out  = ones(0, 3) | ones(8, 19);
        e_busy = ones(0, 31);
        e_done = ones(32, 32);
        checks++;
        if (cap_out !== e_out) begin
            failures++;
            $display("FAIL a_out: got %h expected %h", cap_out, e_out);
        end
        checks++;
        if (cap_busy !== e_busy) begin
            failures++;
            $display("FAIL a_busy: got %h expected %h", cap_busy, e_busy);
        end
        checks++;
        if (cap_done !== e_done) begin
            failures++;
            $display("FAIL a_done: got %h expected %h", cap_done, e_done);
        end
    endtask

    task automatic test_word_space_invalid();
        logic [63:0] e_busy, e_done;
        start_sym(3'd0, 5'b11111);
        capture(32, -1, 0);
        e_busy = ones(0, 27);
        e_done = ones(28, 28);
        checks++;
        if (cap_out !== 64'd0) begin
            failures++;
            $display("FAIL ws_out: got %h expected 0", cap_out);
        end
        checks++;
        if (cap_busy !== e_busy) begin
            failures++;
            $display("FAIL ws_busy: got %h expected %h", cap_busy, e_busy);
        end
        checks++;
        if (cap_done !== e_done) begin
            failures++;
            $display("FAIL ws_done: got %h expected %h", cap_done, e_done);
        end
        start_sym(3'd6, 5'b10101);
        capture(12, -1, 0);
        checks++;
        if (cap_busy !== 64'd0) begin
            failures++;
            $display("FAIL inv_busy: got %h expected 0", cap_busy);
        end
        checks++;
        if (cap_out !== 64'd0) begin
            failures++;
            $display("FAIL inv_out: got %h expected 0", cap_out);
        end
        checks++;
        if (cap_done !== 64'd0) begin
            failures++;
            $display("FAIL inv_done: got %h expected 0", cap_done);
        end
    endtask

    task automatic test_ignore_busy_start();
        logic [63:0] e_out, e_busy, e_done;
        start_sym(3'd1, 5'b00000);
        capture(24, 2, 1);
        e_out  = ones(0, 3);
        e_busy = ones(0, 15);
        e_done = ones(16, 16);
        checks++;
        if (cap_out !== e_out) begin
            failures++;
            $display("FAIL e_ign_out: got %h expected %h", cap_out, e_out);
        end
        checks++;
        if (cap_busy !== e_busy) begin
            failures++;
            $display("FAIL e_ign_busy: got %h expected %h", cap_busy, e_busy);
        end
        checks++;
        if (cap_done !== e_done) begin
            failures++;
            $display("FAIL e_ign_done: got %h expected %h", cap_done, e_done);
        end
    endtask

    task automatic test_reset_mid_mark();
        logic [63:0] e_out, e_busy;
        start_sym(3'd1, 5'b00001);
        capture(40, 6, 2);
        e_out  = ones(0, 6);
        e_busy = ones(0, 6);
        checks++;
        if (cap_out !== e_out) begin
            failures++;
            $display("FAIL t_rst_out: got %h expected %h", cap_out, e_out);
        end
        checks++;
        if (cap_busy !== e_busy) begin
            failures++;
            $display("FAIL t_rst_busy: got %h expected %h", cap_busy, e_busy);
        end
        checks++;
        if (cap_done !== 64'd0) begin
            failures++;
            $display("FAIL t_rst_done: got %h expected 0", cap_done);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] e_out, e_busy, e_done;
        bus.START   = 1'b1;
        bus.SYM_LEN = 3'd1;
        bus.SYM_PAT = 5'b00000;
        @(negedge CLK);
        bus.SYM_PAT = 5'b00001;
        capture(45, 17, 3);
        e_out  = ones(0, 3) | ones(17, 28);
        e_busy = ones(0, 15) | ones(17, 40);
        e_done = ones(16, 16) | ones(41, 41);
        checks++;
        if (cap_out !== e_out) begin
            failures++;
            $display("FAIL b2b_out: got %h expected %h", cap_out, e_out);
        end
        checks++;
        if (cap_busy !== e_busy) begin
            failures++;
            $display("FAIL b2b_busy: got %h expected %h", cap_busy, e_busy);
        end
        checks++;
        if (cap_done !== e_done) begin
            failures++;
            $display("FAIL b2b_done: got %h expected %h", cap_done, e_done);
        end
    endtask

    initial begin
        test_reset();
        test_letter_a();
        test_word_space_invalid();
        test_ignore_busy_start();
        test_reset_mid_mark();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
